// File: rtl/arm_shift_pkg.sv
// arm_shift_pkg: shift-type, operand-class and sequencer state encodings shared by the shifter operand path
package arm_shift_pkg;
    typedef enum logic [1:0] {SH_LSL = 2'b00, SH_LSR = 2'b01, SH_ASR = 2'b10, SH_ROR = 2'b11} shift_t;
    typedef enum logic [1:0] {CL_IMM = 2'b00, CL_DPIS = 2'b01, CL_DPRS = 2'b10} opclass_t;
    typedef enum logic [2:0] {S_IDLE, S_REQ_RS, S_REQ_RM, S_EXEC, S_DONE} state_t;
    // bit25 selects immediate; otherwise bit4 selects register-shifted (bit7 is not inspected)
    function automatic opclass_t decode_class(input logic [31:0] instr);
        return instr[25] ? CL_IMM : (instr[4] ? CL_DPRS : CL_DPIS);
    endfunction
endpackage

// File: rtl/dp_shifter.sv
// dp_shifter: combinational ARM data-processing shifter producing {carry, value}
//   value      : operand to shift (Rm, or zero-extended imm8 for immediates)
//   amount     : shift amount (2*rot for immediates, imm5 for DPIS, Rs[7:0] for DPRS)
//   shift_type : LSL/LSR/ASR/ROR
//   op_class   : IMM/DPIS/DPRS, selects the #0 encodings of the immediate-shift form
//   c_flag     : incoming CPSR C
//   result     : {carry_out, shifted value}
module dp_shifter
    import arm_shift_pkg::*;
(
    input  logic [31:0] value,
    input  logic [7:0]  amount,
    input  logic [1:0]  shift_type,
    input  logic [1:0]  op_class,
    input  logic        c_flag,
    output logic [32:0] result
);
    logic [7:0]  n;
    logic [4:0]  k;
    logic [31:0] r;
    logic [32:0] lsl_w, lsr_w, asr_w;
    logic        rrx;
    always_comb begin
        // DPIS LSR/ASR #0 encode a shift of 32; ROR #0 encodes RRX
        n = (op_class == CL_DPIS && (shift_type == SH_LSR || shift_type == SH_ASR) && amount == 8'd0) ? 8'd32 : amount;
        rrx = op_class == CL_DPIS && shift_type == SH_ROR && amount == 8'd0;
        k = n[4:0];
        // one extra bit on the shifted-out side carries the last bit lost
        lsl_w = {1'b0, value} << n;
        lsr_w = {value, 1'b0} >> n;
        asr_w = $signed({value, 1'b0}) >>> n;
        // with k=0 the rotate degenerates to value and r[31] equals value[31]
        r = (value >> k) | (value << (6'd32 - {1'b0, k}));
        result = rrx ? {value[0], c_flag, value[31:1]}
               : n == 8'd0 ? {c_flag, value}
               : shift_type == SH_LSL ? lsl_w
               : shift_type == SH_LSR ? {lsr_w[0], lsr_w[32:1]}
               : shift_type == SH_ASR ? {asr_w[0], asr_w[32:1]}
               : {r[31], r};
    end
endmodule

// File: rtl/shift_operand_sequencer.sv
// shift_operand_sequencer: fetches Rs/Rm from the register file and evaluates one shifter operand
//   clk, reset          : clock and synchronous active-high reset
//   start, instr, c_flag: request, instruction word and CPSR C (sampled together in IDLE)
//   rf_rd_en/addr/data  : register-file read port, data returned one cycle after the request
//   busy, done          : not-idle indicator and one-cycle completion pulse
//   shifter_operand/carry_out : registered result, held until the next evaluation
module shift_operand_sequencer
    import arm_shift_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] instr,
    input  logic        c_flag,
    output logic        rf_rd_en,
    output logic [3:0]  rf_rd_addr,
    input  logic [31:0] rf_rd_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] shifter_operand,
    output logic        shifter_carry_out
);
    state_t      state_q, state_d;
    logic [31:0] instr_q, instr_d, op_q, op_d;
    logic        c_q, c_d, carry_q, carry_d;
    logic [7:0]  amt_q, amt_d;
    opclass_t    cls, start_cls;
    logic [31:0] sh_val;
    logic [7:0]  sh_amt;
    logic [1:0]  sh_type;
    logic [32:0] sh;
    logic        unused_bits;

    assign unused_bits = ^{instr_q[31:26], instr_q[24:12]};

    always_comb begin
        cls = decode_class(instr_q);
        sh_val = cls == CL_IMM ? {24'd0, instr_q[7:0]} : rf_rd_data;
        sh_amt = cls == CL_IMM ? {3'd0, instr_q[11:8], 1'b0} : cls == CL_DPIS ? {3'd0, instr_q[11:7]} : amt_q;
        sh_type = cls == CL_IMM ? SH_ROR : instr_q[6:5];
    end

    dp_shifter u_shifter (
        .value(sh_val),
        .amount(sh_amt),
        .shift_type(sh_type),
        .op_class(cls),
        .c_flag(c_q),
        .result(sh)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            instr_q <= '0;
            c_q     <= 1'b0;
            amt_q   <= '0;
            op_q    <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            c_q     <= c_d;
            amt_q   <= amt_d;
            op_q    <= op_d;
            carry_q <= carry_d;
        end
    end

    always_comb begin
        start_cls = decode_class(instr);
        state_d = state_q == S_IDLE ? (!start ? S_IDLE : start_cls == CL_DPRS ? S_REQ_RS : start_cls == CL_DPIS ? S_REQ_RM : S_EXEC)
                : state_q == S_REQ_RS ? S_REQ_RM
                : state_q == S_REQ_RM ? S_EXEC
                : state_q == S_EXEC ? S_DONE
                : S_IDLE;
        instr_d = (state_q == S_IDLE && start) ? instr : instr_q;
        c_d = (state_q == S_IDLE && start) ? c_flag : c_q;
        // Rs arrives while Rm is being requested
        amt_d = (state_q == S_REQ_RM && cls == CL_DPRS) ? rf_rd_data[7:0] : amt_q;
        op_d = state_q == S_EXEC ? sh[31:0] : op_q;
        carry_d = state_q == S_EXEC ? sh[32] : carry_q;
    end

    always_comb begin
        busy = state_q != S_IDLE;
        done = state_q == S_DONE;
        rf_rd_en = state_q == S_REQ_RS || state_q == S_REQ_RM;
        rf_rd_addr = state_q == S_REQ_RS ? instr_q[11:8] : state_q == S_REQ_RM ? instr_q[3:0] : 4'd0;
        shifter_operand = op_q;
        shifter_carry_out = carry_q;
    end
endmodule

// File: tb/tb_shift_operand_sequencer.sv
// tb_shift_operand_sequencer: directed and random checks against a behavioural shifter-operand model
module tb_shift_operand_sequencer;
    logic        clk = 0;
    logic        reset = 1;
    logic        start = 0;
    logic [31:0] instr = 0;
    logic        c_flag = 0;
    logic        rf_rd_en;
    logic [3:0]  rf_rd_addr;
    logic [31:0] rf_rd_data = 0;
    logic        busy, done;
    logic [31:0] shifter_operand;
    logic        shifter_carry_out;

    logic [31:0] regs [16];
    logic [3:0]  rd_q [$];
    int n_cmp = 0;
    int n_err = 0;

    shift_operand_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .instr(instr), .c_flag(c_flag),
        .rf_rd_en(rf_rd_en), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
        .busy(busy), .done(done), .shifter_operand(shifter_operand),
        .shifter_carry_out(shifter_carry_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rf_rd_data <= rf_rd_en ? regs[rf_rd_addr] : 32'hDEAD_BEEF;
    always @(negedge clk) if (rf_rd_en) rd_q.push_back(rf_rd_addr);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [32:0] reg_shift(input logic [1:0] t, input int n, input logic c, input logic [31:0] rm);
        logic [63:0] x;
        int k;
        if (n == 0) return {c, rm};
        case (t)
            2'b00: return n < 32 ? {rm[32-n], rm << n} : n == 32 ? {rm[0], 32'd0} : 33'd0;
            2'b01: return n < 32 ? {rm[n-1], rm >> n} : n == 32 ? {rm[31], 32'd0} : 33'd0;
            2'b10: begin
                x = {{32{rm[31]}}, rm} >> (n < 32 ? n : 32);
                return n < 32 ? {rm[n-1], x[31:0]} : {rm[31], {32{rm[31]}}};
            end
            default: begin
                k = n % 32;
                x = {rm, rm} >> k;
                return k == 0 ? {rm[31], rm} : {rm[k-1], x[31:0]};
            end
        endcase
    endfunction

    function automatic logic [32:0] ref_op(input logic [31:0] ins, input logic c, input logic [31:0] rs, input logic [31:0] rm);
        logic [63:0] x;
        int n;
        if (ins[25]) begin
            if (ins[11:8] == 0) return {c, 24'd0, ins[7:0]};
            x = {24'd0, ins[7:0], 24'd0, ins[7:0]} >> (2 * int'(ins[11:8]));
            return {x[31], x[31:0]};
        end
        if (ins[4]) return reg_shift(ins[6:5], int'(rs[7:0]), c, rm);
        n = int'(ins[11:7]);
        if (n == 0 && ins[6:5] == 2'b11) return {rm[0], c, rm[31:1]};
        if (n == 0 && (ins[6:5] == 2'b01 || ins[6:5] == 2'b10)) n = 32;
        return reg_shift(ins[6:5], n, c, rm);
    endfunction

    task automatic run_op(input logic [31:0] ins, input logic c, input string tag);
        logic [32:0] exp;
        int lat, exp_lat, exp_nrd;
        exp = ref_op(ins, c, regs[ins[11:8]], regs[ins[3:0]]);
        exp_lat = ins[25] ? 2 : ins[4] ? 4 : 3;
        exp_nrd = ins[25] ? 0 : ins[4] ? 2 : 1;
        @(negedge clk);
        rd_q.delete();
        instr = ins;
        c_flag = c;
        start = 1;
        @(posedge clk);
        #1 start = 0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) check({tag, " busy"}, busy, 1);
        end while (!done && lat < 8);
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " operand"}, shifter_operand, exp[31:0]);
        check({tag, " carry"}, shifter_carry_out, exp[32]);
        check({tag, " reads"}, rd_q.size(), exp_nrd);
        if (exp_nrd == 2 && rd_q.size() == 2) begin
            check({tag, " rs addr"}, rd_q[0], ins[11:8]);
            check({tag, " rm addr"}, rd_q[1], ins[3:0]);
        end
        if (exp_nrd == 1 && rd_q.size() == 1) check({tag, " rm addr"}, rd_q[0], ins[3:0]);
        @(negedge clk);
        check({tag, " done pulse"}, {busy, done}, 2'b00);
        check({tag, " hold"}, {shifter_carry_out, shifter_operand}, exp);
    endtask

    task automatic count_dones(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done) cnt++;
        end
    endtask

    initial begin
        logic [31:0] ins;
        logic [32:0] exp;
        int cnt;
        for (int i = 0; i < 16; i++) regs[i] = $urandom;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        check("reset outputs", {busy, done, rf_rd_en, rf_rd_addr, shifter_carry_out, shifter_operand}, 0);

        run_op(32'h02A001FF, 0, "imm rot1");
        regs[1] = 32'h120; regs[2] = 32'h1;
        run_op(32'h01A00112, 0, "dprs lsl32");
        regs[1] = 32'h21;
        run_op(32'h01A00112, 1, "dprs lsl33");
        regs[2] = 32'h3;
        run_op(32'h01A00062, 1, "dpis rrx");
        regs[1] = 40; regs[2] = 32'h8000_0000;
        run_op(32'h01A00152, 0, "dprs asr40");
        regs[1] = 32'hF00; regs[2] = 32'h1234_5678;
        run_op(32'h01A00152, 0, "dprs asr0");

        regs[5] = 32'hF000_000F;
        ins = 32'h01A000A5;
        exp = ref_op(ins, 0, regs[0], regs[5]);
        @(negedge clk);
        instr = ins; c_flag = 0; start = 1;
        @(posedge clk);
        #1 start = 0;
        @(negedge clk);
        instr = 32'h02A0_04FF; start = 1;
        @(posedge clk);
        #1 start = 0;
        count_dones(10, cnt);
        check("busy start ignored", cnt, 1);
        check("busy start operand", {shifter_carry_out, shifter_operand}, exp);

        for (int t = 0; t < 300; t++) begin
            int kind, sel;
            ins = $urandom;
            kind = $urandom_range(0, 2);
            ins[25] = kind == 0;
            ins[4] = kind == 2;
            for (int i = 0; i < 16; i++) regs[i] = $urandom;
            sel = $urandom_range(0, 5);
            if (sel == 0) regs[ins[11:8]][7:0] = 0;
            if (sel == 1) regs[ins[11:8]][7:0] = 32;
            if (sel == 2) regs[ins[11:8]][7:0] = 33;
            if (sel == 3) regs[ins[11:8]][7:0] = 31;
            if (sel == 4) regs[ins[11:8]][7:0] = 8'($urandom_range(1, 31));
            run_op(ins, 1'($urandom), "random");
        end

        run_op(32'h02A0_02F3, 1, "imm pre-reset");
        regs[7] = 4; regs[8] = 32'hABCD_1234;
        @(negedge clk);
        instr = 32'h01A00718; c_flag = 1; start = 1;
        @(posedge clk);
        #1 start = 0;
        @(negedge clk);
        @(negedge clk);
        check("req_rm addr", {rf_rd_en, rf_rd_addr}, {1'b1, 4'd8});
        reset = 1;
        @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        check("abort outputs", {busy, done, rf_rd_en, rf_rd_addr, shifter_carry_out, shifter_operand}, 0);
        count_dones(6, cnt);
        check("abort no done", cnt, 0);

        @(negedge clk);
        reset = 1; start = 1; instr = 32'h02A001FF;
        @(posedge clk);
        #1 reset = 0; start = 0;
        @(negedge clk);
        check("start with reset", busy, 0);
        count_dones(4, cnt);
        check("start with reset done", cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/shift_operand_sequencer.md
SHIFT_OPERAND_SEQUENCER -- requirements
Module: shift_operand_sequencer

Interface
REQ-001 SHALL have ports: clk  input  1  sole clock, all state changes on rising edge.
REQ-002 SHALL have: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have: start  input  1  request to evaluate one data-processing shifter operand.
REQ-004 SHALL have: instr  input  32  ARMv4 data-processing instruction word, sampled with start.
REQ-005 SHALL have: c_flag  input  1  CPSR C, sampled with start.
REQ-006 SHALL have: rf_rd_en  output  1 and rf_rd_addr  output  4  register-file read request.
REQ-007 SHALL have: rf_rd_data  input  32  read data, valid the cycle after rf_rd_en.
REQ-008 SHALL have: busy  output  1; done  output  1 (one-cycle pulse).
REQ-009 SHALL have: shifter_operand  output  32 and shifter_carry_out  output  1.

Function
REQ-010 SHALL decode from the latched instr: immediate if bit25=1; DPIS if bit25=0 and bit4=0; DPRS if bit25=0, bit4=1, bit7=0. bit25=0, bit4=1, bit7=1 SHALL be treated as DPRS.
REQ-011 SHALL use FSM states IDLE, REQ_RS, REQ_RM, EXEC, DONE.
REQ-012 In IDLE, start=1 SHALL latch instr/c_flag; next state is REQ_RS (DPRS), REQ_RM (DPIS) or EXEC (immediate).
REQ-013 REQ_RS SHALL drive rf_rd_en=1, rf_rd_addr=instr[11:8]; next state is REQ_RM.
REQ-014 REQ_RM SHALL drive rf_rd_en=1, rf_rd_addr=instr[3:0]; for DPRS it SHALL capture rf_rd_data[7:0] as the shift amount; next state is EXEC.
REQ-015 EXEC SHALL compute from rf_rd_data (Rm) and register shifter_operand and shifter_carry_out; next state is DONE.
REQ-016 DONE SHALL assert done=1 for exactly one cycle; next state is IDLE.
REQ-017 Start-to-done latency SHALL be 4 cycles for DPRS, 3 for DPIS, and 2 for immediate; done is first high N cycles after the start sample edge.
REQ-018 busy SHALL be 1 in every state except IDLE; start while busy SHALL be ignored.
REQ-019 rf_rd_en SHALL be 0 outside REQ_RS/REQ_RM.
REQ-020 shifter_operand and carry SHALL hold their value until the next EXEC.
REQ-021 Immediate: rot=instr[11:8], imm=instr[7:0]. rot=0 gives imm with carry c_flag; otherwise ror(imm,2*rot) with carry = result[31].
REQ-022 DPIS with amt=instr[11:7] and type=instr[6:5]:
- LSL #0 gives Rm with carry c_flag.
- LSR #0 / ASR #0 mean a shift of 32.
- ROR #0 is RRX, giving {c_flag,Rm[31:1]} with carry Rm[0].
REQ-023 DPRS with 8-bit amt n:
- n=0 gives Rm with carry c_flag for all types.
- LSL: n<32 gives Rm<<n, carry Rm[32-n]; n=32 gives 0, carry Rm[0]; n>32 gives 0, carry 0.
- LSR: n<32 gives Rm>>n, carry Rm[n-1]; n=32 gives 0, carry Rm[31]; n>32 gives 0, carry 0.
- ASR: n>=32 gives all bits and carry = Rm[31].
- ROR: n[4:0]=0 gives Rm, carry Rm[31]; otherwise ror by n[4:0], carry Rm[n[4:0]-1].
REQ-024 Register 15 SHALL receive no special handling; rf_rd_data is used as returned.

Reset
REQ-025 reset=1 at a clock edge SHALL force IDLE with busy=0, done=0, rf_rd_en=0, rf_rd_addr=0, shifter_operand=0, shifter_carry_out=0.
REQ-026 Reset mid-operation SHALL abort the operation with no done pulse; start in the same cycle as reset SHALL be ignored.

Structure
REQ-027 Shift-type codes (LSL=00, LSR=01, ASR=10, ROR=11), FSM state encoding and operand-class codes SHALL live in package arm_shift_pkg.
REQ-028 Shift arithmetic SHALL be one combinational sub-module, dp_shifter, producing a 33-bit {carry, value} from value, amount, type, class and c_flag; the sequencer owns all state.

Verification
REQ-029 Immediate: instr=0x02A001FF (rot=1, imm=0xFF), c_flag=0 -> done after 2 cycles, operand 0xC000003F, carry 1.
REQ-030 DPRS LSL: Rs=0x00000120 (n=0x20), Rm=0x00000001, instr=0x01A00112 -> rf_rd_addr 1 then 2, done after 4 cycles, operand 0, carry 1; repeat with n=0x21 -> operand 0, carry 0.
REQ-031 DPIS RRX: instr=0x01A00062 (ROR #0), Rm=0x00000003, c_flag=1 -> done after 3 cycles, operand 0x80000001, carry 1.
REQ-032 DPRS ASR: n=40, Rm=0x80000000 -> operand 0xFFFFFFFF, carry 1; n=0, c_flag=0 -> operand Rm, carry 0.
REQ-033 Start pulsed during busy -> ignored, exactly one done; reset asserted in REQ_RM -> next cycle IDLE, no done, all outputs 0.
